timeout_sched: RTL and testbench

TIMEOUT_SCHED -- requirements
Module: timeout_sched

---
 rtl/timeout_sched.sv | 175 +++++++++++++++++
 tb/tb_timeout_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timeout_sched.sv
// Retransmission-timeout scheduler: coalesces timer expiries per flow and offers
// eligible flows round-robin to the timeout pipeline. Optional counters: TIMEOUT_SCHED_STATS_EN.
module timeout_sched #(
  parameter int NUM_FLOWS = 16,
  parameter int FID_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             expire_valid,
  input  logic [FID_W-1:0] expire_fid,
  input  logic             cancel_valid,
  input  logic [FID_W-1:0] cancel_fid,
  output logic             out_valid,
  output logic [FID_W-1:0] out_fid,
  input  logic             out_ready,
  input  logic             done_valid,
  input  logic [FID_W-1:0] done_fid,
  output logic [FID_W:0]   pend_cnt
`ifdef TIMEOUT_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_coalesced
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_FLOWS-1:0]   pending_q, pending_d;
  logic [NUM_FLOWS-1:0]   inflight_q, inflight_d;
  logic [FID_W-1:0]       rr_q, rr_d;
  logic [FID_W-1:0]       fid_q, fid_d;
  logic [FID_W:0]         cnt_q, cnt_d;

  logic [NUM_FLOWS-1:0]   elig;
  logic                   sel_found;
  logic [FID_W-1:0]       sel_fid;
  logic                   load_en;
  logic                   do_load;

  // First set bit of vec at or after base, wrapping past the top index.
  function automatic logic [FID_W:0] rr_pick(input logic [NUM_FLOWS-1:0] vec,
                                             input logic [FID_W-1:0]     base);
    logic             found;
    logic [FID_W-1:0] idx;
    logic [FID_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      cand = base + i[FID_W-1:0];
      if (!found && vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [FID_W:0] popcount(input logic [NUM_FLOWS-1:0] vec);
    logic [FID_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      c = c + {{FID_W{1'b0}}, vec[i]};
    end
    return c;
  endfunction

  // Selection sees only registered state, never this cycle's expire/done.
  always_comb begin
    elig                 = pending_q & ~inflight_q;
    {sel_found, sel_fid} = rr_pick(elig, rr_q);
  end

  always_comb begin
    state_d = state_q;
    fid_d   = fid_q;
    rr_d    = rr_q;
    load_en = 1'b0;
    do_load = 1'b0;
    case (state_q)
      EMPTY:   load_en = 1'b1;
      FULL:    load_en = out_ready;
      default: load_en = 1'b0;
    endcase
    if (load_en) begin
      if (sel_found) begin
        do_load = 1'b1;
        state_d = FULL;
        fid_d   = sel_fid;
        rr_d    = sel_fid + {{(FID_W-1){1'b0}}, 1'b1};
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // Expire is applied last so it beats both cancel and the issue-clear.
  always_comb begin
    pending_d  = pending_q;
    inflight_d = inflight_q;
    if (do_load) begin
      pending_d[sel_fid]  = 1'b0;
    end
    if (cancel_valid) begin
      pending_d[cancel_fid] = 1'b0;
    end
    if (expire_valid) begin
      pending_d[expire_fid] = 1'b1;
    end
    if (done_valid) begin
      inflight_d[done_fid] = 1'b0;
    end
    if (do_load) begin
      inflight_d[sel_fid] = 1'b1;
    end
    cnt_d = popcount(pending_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      pending_q  <= '0;
      inflight_q <= '0;
      rr_q       <= '0;
      fid_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      rr_q       <= rr_d;
      fid_q      <= fid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_fid   = fid_q;
  assign pend_cnt  = cnt_q;

`ifdef TIMEOUT_SCHED_STATS_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] coal_q, coal_d;

  always_comb begin
    issued_d = issued_q;
    coal_d   = coal_q;
    if (out_valid && out_ready && (issued_q != 32'hFFFF_FFFF)) begin
      issued_d = issued_q + 32'd1;
    end
    if (expire_valid && pending_q[expire_fid] && (coal_q != 32'hFFFF_FFFF)) begin
      coal_d = coal_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      coal_q   <= '0;
    end else begin
      issued_q <= issued_d;
      coal_q   <= coal_d;
    end
  end

  assign stat_issued    = issued_q;
  assign stat_coalesced = coal_q;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_timeout_sched.sv
// Directed testbench for timeout_sched; inputs change and outputs are sampled on the falling edge.
module tb_timeout_sched;

  localparam int NUM_FLOWS = 16;
  localparam int FID_W     = 4;

  logic             clk;
  logic             rst;
  logic             expire_valid;
  logic [FID_W-1:0] expire_fid;
  logic             cancel_valid;
  logic [FID_W-1:0] cancel_fid;
  logic             out_valid;
  logic [FID_W-1:0] out_fid;
  logic             out_ready;
  logic             done_valid;
  logic [FID_W-1:0] done_fid;
  logic [FID_W:0]   pend_cnt;
`ifdef TIMEOUT_SCHED_STATS_EN
  logic [31:0]      stat_issued;
  logic [31:0]      stat_coalesced;
`endif

  int errors = 0;
  int checks = 0;

  timeout_sched #(.NUM_FLOWS(NUM_FLOWS), .FID_W(FID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .expire_valid (expire_valid),
    .expire_fid   (expire_fid),
    .cancel_valid (cancel_valid),
    .cancel_fid   (cancel_fid),
    .out_valid    (out_valid),
    .out_fid      (out_fid),
    .out_ready    (out_ready),
    .done_valid   (done_valid),
    .done_fid     (done_fid),
    .pend_cnt     (pend_cnt)
`ifdef TIMEOUT_SCHED_STATS_EN
    ,
    .stat_issued    (stat_issued),
    .stat_coalesced (stat_coalesced)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    expire_valid = 1'b0;
    expire_fid   = '0;
    cancel_valid = 1'b0;
    cancel_fid   = '0;
    done_valid   = 1'b0;
    done_fid     = '0;
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    idle_inputs();
    out_ready = rdy;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_fid !== 4'd0) begin errors++; $display("FAIL reset_fid got=%0d exp=0", out_fid); end
    checks++; if (pend_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", pend_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_issue();
    do_reset(1'b1);
    expire_valid = 1'b1; expire_fid = 4'd5;
    @(negedge clk);
    expire_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e1 got=%0b exp=0", out_valid); end
    checks++; if (pend_cnt !== 5'd1) begin errors++; $display("FAIL single_cnt_e1 got=%0d exp=1", pend_cnt); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_fid !== 4'd5) begin errors++; $display("FAIL single_offer got=%0b/%0d exp=1/5", out_valid, out_fid); end
    checks++; if (pend_cnt !== 5'd0) begin errors++; $display("FAIL single_cnt_e2 got=%0d exp=0", pend_cnt); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [FID_W-1:0] exp_order [3];
    exp_order[0] = 4'd12; exp_order[1] = 4'd3; exp_order[2] = 4'd9;
    do_reset(1'b0);
    expire_valid = 1'b1; expire_fid = 4'd9;
    @(negedge clk);
    expire_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_fid !== 4'd9) begin errors++; $display("FAIL rr_hold9 got=%0b/%0d exp=1/9", out_valid, out_fid); end
    done_valid = 1'b1; done_fid = 4'd9;
    @(negedge clk);
    done_valid = 1'b0;
    expire_valid = 1'b1; expire_fid = 4'd3;
    @(negedge clk);
    expire_fid = 4'd9;
    @(negedge clk);
    expire_fid = 4'd12;
    @(negedge clk);
    expire_valid = 1'b0;
    checks++; if (pend_cnt !== 5'd3) begin errors++; $display("FAIL rr_cnt3 got=%0d exp=3", pend_cnt); end
    checks++; if (out_fid !== 4'd9) begin errors++; $display("FAIL rr_still9 got=%0d exp=9", out_fid); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_fid !== exp_order[k]) begin
        errors++; $display("FAIL rr_order%0d got=%0b/%0d exp=1/%0d", k, out_valid, out_fid, exp_order[k]);
      end
    end
    checks++; if (pend_cnt !== 5'd0) begin errors++; $display("FAIL rr_cnt0 got=%0d exp=0", pend_cnt); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_hold_cancel();
    do_reset(1'b0);
    expire_valid = 1'b1; expire_fid = 4'd7;
    @(negedge clk);
    expire_valid = 1'b0;
    @(negedge clk);
    cancel_valid = 1'b1; cancel_fid = 4'd7;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_fid !== 4'd7) begin
        errors++; $display("FAIL hold_c%0d got=%0b/%0d exp=1/7", k, out_valid, out_fid);
      end
      @(negedge clk);
      cancel_valid = 1'b0;
    end
    expire_valid = 1'b1; expire_fid = 4'd8;
    @(negedge clk);
    expire_valid = 1'b0;
    checks++; if (pend_cnt !== 5'd1) begin errors++; $display("FAIL cancel_pend8 got=%0d exp=1", pend_cnt); end
    cancel_valid = 1'b1; cancel_fid = 4'd8;
    @(negedge clk);
    cancel_valid = 1'b0;
    checks++; if (pend_cnt !== 5'd0) begin errors++; $display("FAIL cancel_clr8 got=%0d exp=0", pend_cnt); end
    checks++; if (out_valid !== 1'b1 || out_fid !== 4'd7) begin errors++; $display("FAIL hold_after got=%0b/%0d exp=1/7", out_valid, out_fid); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_accept got=%0b exp=0", out_valid); end
  endtask

  task automatic test_inflight();
    do_reset(1'b1);
    expire_valid = 1'b1; expire_fid = 4'd2;
    @(negedge clk);
    expire_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_fid !== 4'd2) begin errors++; $display("FAIL infl_issue got=%0b/%0d exp=1/2", out_valid, out_fid); end
    expire_valid = 1'b1; expire_fid = 4'd2;
    @(negedge clk);
    expire_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL infl_noreissue got=%0b exp=0", out_valid); end
    checks++; if (pend_cnt !== 5'd1) begin errors++; $display("FAIL infl_pend got=%0d exp=1", pend_cnt); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL infl_wait got=%0b exp=0", out_valid); end
    done_valid = 1'b1; done_fid = 4'd2;
    @(negedge clk);
    done_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL infl_done_t1 got=%0b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_fid !== 4'd2) begin errors++; $display("FAIL infl_reissue got=%0b/%0d exp=1/2", out_valid, out_fid); end
    checks++; if (pend_cnt !== 5'd0) begin errors++; $display("FAIL infl_cnt0 got=%0d exp=0", pend_cnt); end
  endtask

  task automatic test_expire_cancel();
    do_reset(1'b0);
    expire_valid = 1'b1; expire_fid = 4'd4;
    cancel_valid = 1'b1; cancel_fid = 4'd4;
    @(negedge clk);
    expire_valid = 1'b0; cancel_valid = 1'b0;
    checks++; if (pend_cnt !== 5'd1) begin errors++; $display("FAIL ec_pend got=%0d exp=1", pend_cnt); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_fid !== 4'd4) begin errors++; $display("FAIL ec_issue got=%0b/%0d exp=1/4", out_valid, out_fid); end
`ifdef TIMEOUT_SCHED_STATS_EN
    expire_valid = 1'b1; expire_fid = 4'd4;
    @(negedge clk);
    @(negedge clk);
    expire_valid = 1'b0;
    checks++; if (stat_coalesced !== 32'd1) begin errors++; $display("FAIL stat_coal got=%0d exp=1", stat_coalesced); end
    checks++; if (stat_issued !== 32'd0) begin errors++; $display("FAIL stat_iss got=%0d exp=0", stat_issued); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (stat_issued !== 32'd1) begin errors++; $display("FAIL stat_iss1 got=%0d exp=1", stat_issued); end
`endif
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    for (int f = 1; f <= 4; f++) begin
      expire_valid = 1'b1; expire_fid = f[FID_W-1:0];
      @(negedge clk);
    end
    expire_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_fid !== 4'd1) begin errors++; $display("FAIL ar_full got=%0b/%0d exp=1/1", out_valid, out_fid); end
    checks++; if (pend_cnt !== 5'd3) begin errors++; $display("FAIL ar_cnt3 got=%0d exp=3", pend_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%0b exp=0", out_valid); end
    checks++; if (pend_cnt !== 5'd0) begin errors++; $display("FAIL ar_cnt got=%0d exp=0", pend_cnt); end
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || pend_cnt !== 5'd0) begin
        errors++; $display("FAIL ar_post%0d got=%0b/%0d exp=0/0", k, out_valid, pend_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_round_robin();
    test_hold_cancel();
    test_inflight();
    test_expire_cancel();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
